// File: rtl/shared_memory_mp.sv
// Multi-port line memory. A round-robin arbiter feeds byte-masked writes and
// credit-limited reads that leave a fixed-latency pipeline into a response FIFO.
module shared_memory_mp #(
  parameter int NUM_PORTS    = 4,
  parameter int MEM_BYTES    = 8*1024*1024,
  parameter int LINE_BYTES   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = LINE_BYTES*8,
  parameter int READ_LATENCY = 4,
  parameter int RESP_DEPTH   = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int PW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*LINE_BYTES-1:0]  req_be,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic [PW-1:0]                    resp_port,
  output logic [TAG_WIDTH-1:0]             resp_tag
);

  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int LINES       = MEM_BYTES / LINE_BYTES;
  localparam int INDEX_BITS  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW          = $clog2(RESP_DEPTH + 1);
  localparam int FPW         = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [LINES];

  logic [PW-1:0]         rr;
  logic [CW-1:0]         outstanding;
  logic                  credit_ok;
  logic                  gnt_any;
  logic [PW-1:0]         gnt_id;
  int                    cand;

  logic                  gnt_write;
  logic [INDEX_BITS-1:0] gnt_idx;
  logic [LINE_BYTES-1:0] gnt_be;
  logic [TAG_WIDTH-1:0]  gnt_tag;
  logic [DATA_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0] wr_line;
  logic                  accept_read;
  logic                  accept_write;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic [PW-1:0]           pipe_port [READ_LATENCY];
  logic [TAG_WIDTH-1:0]    pipe_tag  [READ_LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
  logic [PW-1:0]         fifo_port [RESP_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RESP_DEPTH];
  logic [FPW-1:0]        wr_ptr;
  logic [FPW-1:0]        rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic                  push;
  logic                  pop;

  function automatic logic [FPW-1:0] ptr_next(input logic [FPW-1:0] p);
    return (p == FPW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads need a free credit; writes never do, so a blocked read cannot stall them.
  assign credit_ok = (outstanding < CW'(RESP_DEPTH));

  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    cand      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (int'(rr) + i) % NUM_PORTS;
      if (!gnt_any && rst_n && req_valid[cand] && (req_write[cand] || credit_ok)) begin
        gnt_any = 1'b1;
        gnt_id  = PW'(cand);
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  // Offset bits and address bits above the index are dropped, so addresses wrap.
  always_comb begin
    gnt_write = req_write[gnt_id];
    gnt_idx   = req_addr[int'(gnt_id)*ADDR_WIDTH + OFFSET_BITS +: INDEX_BITS];
    gnt_be    = req_be[int'(gnt_id)*LINE_BYTES +: LINE_BYTES];
    gnt_tag   = req_tag[int'(gnt_id)*TAG_WIDTH +: TAG_WIDTH];
    rd_line   = mem[gnt_idx];
    wr_line   = rd_line;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (gnt_be[b]) wr_line[b*8 +: 8] = req_wdata[int'(gnt_id)*DATA_WIDTH + b*8 +: 8];
    end
  end

  assign accept_read  = gnt_any && !gnt_write;
  assign accept_write = gnt_any && gnt_write;
  assign push         = pipe_valid[READ_LATENCY-1];
  assign pop          = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (accept_write) mem[gnt_idx] <= wr_line;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr          <= '0;
      pipe_valid  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (gnt_any) rr <= (int'(gnt_id) == NUM_PORTS - 1) ? '0 : gnt_id + 1'b1;
      pipe_valid[0] <= accept_read;
      for (int s = 1; s < READ_LATENCY; s++) pipe_valid[s] <= pipe_valid[s-1];
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      fifo_count  <= fifo_count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(accept_read) - CW'(pop);
    end
  end

  // Payload registers carry no reset; only the valid bits and pointers matter.
  always_ff @(posedge clk) begin
    pipe_data[0] <= rd_line;
    pipe_port[0] <= gnt_id;
    pipe_tag[0]  <= gnt_tag;
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_data[s] <= pipe_data[s-1];
      pipe_port[s] <= pipe_port[s-1];
      pipe_tag[s]  <= pipe_tag[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= pipe_data[READ_LATENCY-1];
      fifo_port[wr_ptr] <= pipe_port[READ_LATENCY-1];
      fifo_tag[wr_ptr]  <= pipe_tag[READ_LATENCY-1];
    end
  end

  assign resp_valid = rst_n && (fifo_count != '0);
  assign resp_rdata = resp_valid ? fifo_data[rd_ptr] : '0;
  assign resp_port  = resp_valid ? fifo_port[rd_ptr] : '0;
  assign resp_tag   = resp_valid ? fifo_tag[rd_ptr]  : '0;

endmodule

// File: tb/tb_shared_memory_mp.sv
// Randomized and directed bench for shared_memory_mp, checked against a
// transaction-level model (line array plus an ordered queue of pending reads).
module tb_shared_memory_mp;

  localparam int NP    = 4;
  localparam int MB    = 64*1024;
  localparam int LB    = 64;
  localparam int AW    = 64;
  localparam int DW    = LB*8;
  localparam int RL    = 4;
  localparam int RD    = 4;
  localparam int TW    = 4;
  localparam int PW    = 2;
  localparam int LINES = MB / LB;
  localparam int CHKW  = DW + 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*LB-1:0] req_be;
  logic [NP*TW-1:0] req_tag;
  logic [NP-1:0]    req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [DW-1:0]    resp_rdata;
  logic [PW-1:0]    resp_port;
  logic [TW-1:0]    resp_tag;

  shared_memory_mp #(
    .NUM_PORTS(NP), .MEM_BYTES(MB), .LINE_BYTES(LB), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .READ_LATENCY(RL), .RESP_DEPTH(RD), .TAG_WIDTH(TW), .PW(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_tag(req_tag),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_port(resp_port), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    int            tag;
    logic [DW-1:0] data;
    int            vis;
  } resp_t;

  resp_t         q[$];
  logic [DW-1:0] mmem [int];
  int            m_rr = 0;
  int            cyc = 0;
  int            last_gnt = -1;
  int            dut_pops = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  logic [NP-1:0] obs_ready;

  task automatic checkOutput(input string tag, input logic [CHKW-1:0] got,
                             input logic [CHKW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int lineOf(input logic [AW-1:0] a);
    return int'((a >> 6) % AW'(LINES));
  endfunction

  function automatic logic [DW-1:0] randLine();
    logic [DW-1:0] l;
    for (int w = 0; w < DW/32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic clearReqs();
    req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_be = '0; req_tag = '0;
  endtask

  task automatic dropReq(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic applyStimulus(input int p, input bit wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [LB-1:0] be,
                               input int tag);
    req_valid[p]          = 1'b1;
    req_write[p]          = wr;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_be[p*LB +: LB]    = be;
    req_tag[p*TW +: TW]   = TW'(tag);
  endtask

  // First eligible port scanning upward from the model's round-robin pointer.
  function automatic int expGrant();
    int p;
    if (!rst_n) return -1;
    for (int i = 0; i < NP; i++) begin
      p = (m_rr + i) % NP;
      if (req_valid[p] && (req_write[p] || q.size() < RD)) return p;
    end
    return -1;
  endfunction

  // Checks outputs mid-cycle, then advances the model across one rising edge.
  task automatic stepCycle();
    int            g;
    int            idx;
    bit            exp_rv;
    logic [DW-1:0] line;
    logic [LB-1:0] be;
    #2;
    g = expGrant();
    obs_ready = req_ready;
    checkOutput("req_ready", req_ready, (g >= 0) ? (4'b0001 << g) : 4'b0000);
    exp_rv = rst_n && (q.size() > 0) && (q[0].vis <= cyc);
    checkOutput("resp_valid", resp_valid, exp_rv);
    if (exp_rv) begin
      checkOutput("resp_port", resp_port, q[0].port);
      checkOutput("resp_tag", resp_tag, q[0].tag);
      checkOutput("resp_rdata", resp_rdata, q[0].data);
    end else begin
      checkOutput("resp_idle_zero", {resp_port, resp_tag, resp_rdata}, '0);
    end
    if (resp_valid && resp_ready) dut_pops++;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_rr = 0;
      last_gnt = -1;
    end else begin
      if (exp_rv && resp_ready) void'(q.pop_front());
      last_gnt = g;
      if (g >= 0) begin
        m_rr = (g + 1) % NP;
        idx = lineOf(req_addr[g*AW +: AW]);
        if (req_write[g]) begin
          line = mmem.exists(idx) ? mmem[idx] : '0;
          be = req_be[g*LB +: LB];
          for (int b = 0; b < LB; b++)
            if (be[b]) line[b*8 +: 8] = req_wdata[g*DW + b*8 +: 8];
          mmem[idx] = line;
        end else begin
          q.push_back('{port: g, tag: int'(req_tag[g*TW +: TW]), data: mmem[idx], vis: cyc + RL});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic waitGrant(input int p);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      stepCycle();
      if (last_gnt == p) ok = 1;
    end
    checkOutput("grant_wait", ok, 1);
  endtask

  task automatic waitResp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 12) begin
      stepCycle();
      lat++;
    end
  endtask

  task automatic drain();
    clearReqs();
    resp_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) stepCycle();
    stepCycle();
    checkOutput("drain_empty", resp_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            lat;
    int            acc;
    int            n;
    int            p0;
    logic [DW-1:0] pat;
    logic [TW+DW-1:0] held;
    bit            stalled;

    clearReqs();
    resp_ready = 1'b0;
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset_ready", req_ready, 0);
    checkOutput("reset_resp_valid", resp_valid, 0);
    rst_n = 1'b1;

    // Byte-masked merge then read-back with port/tag echo.
    applyStimulus(0, 1, 'h1000, {64{8'hAA}}, {64{1'b1}}, 0);
    waitGrant(0);
    clearReqs();
    applyStimulus(1, 1, 'h1000, {64{8'h55}}, 64'h0F, 0);
    waitGrant(1);
    clearReqs();
    applyStimulus(2, 0, 'h1000, '0, '0, 3);
    waitGrant(2);
    clearReqs();
    resp_ready = 1'b1;
    waitResp(lat);
    checkOutput("bm_latency", lat, RL);
    checkOutput("bm_data", resp_rdata, {{60{8'hAA}}, {4{8'h55}}});
    checkOutput("bm_port", resp_port, 2);
    checkOutput("bm_tag", resp_tag, 3);
    drain();

    // Round-robin order from reset with every port writing.
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) applyStimulus(p, 1, AW'((16 + p) * LB), randLine(), {64{1'b1}}, 0);
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("rr_order", obs_ready, 4'b0001 << (i % 4));
    end
    clearReqs();

    // Credit limit: reads stall at RD outstanding, writes still pass.
    resp_ready = 1'b0;
    acc = 0;
    applyStimulus(0, 0, 'h1000, '0, '0, acc);
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      if (obs_ready[0]) begin
        acc++;
        applyStimulus(0, 0, 'h1000, '0, '0, acc);
      end
    end
    checkOutput("credit_accepts", acc, 4);
    applyStimulus(1, 1, AW'(68 * LB), randLine(), {64{1'b1}}, 0);
    stepCycle();
    checkOutput("credit_write_gnt", obs_ready, 4'b0010);
    dropReq(1);
    p0 = dut_pops;
    resp_ready = 1'b1;
    for (int k = 0; k < 20 && acc < 6; k++) begin
      stepCycle();
      if (obs_ready[0]) begin
        acc++;
        if (acc < 6) applyStimulus(0, 0, 'h1000, '0, '0, acc);
        else dropReq(0);
      end
    end
    checkOutput("credit_total", acc, 6);
    drain();
    checkOutput("credit_pops", dut_pops - p0, 6);

    // Backpressure: head must hold while the consumer stalls.
    p0 = dut_pops;
    n = 0;
    applyStimulus(2, 0, 'h1000, '0, '0, 8);
    for (int k = 0; k < 80 && (n < 4 || q.size() > 0); k++) begin
      resp_ready = $urandom_range(0, 1);
      stalled = resp_valid && !resp_ready;
      held = {resp_tag, resp_rdata};
      stepCycle();
      if (stalled) checkOutput("bp_hold", {resp_tag, resp_rdata}, held);
      if (last_gnt == 2) begin
        n++;
        if (n < 4) applyStimulus(2, 0, 'h1000, '0, '0, 8 + n);
        else dropReq(2);
      end
    end
    checkOutput("bp_accepts", n, 4);
    drain();
    checkOutput("bp_pops", dut_pops - p0, 4);

    // Address wrap modulo the memory size.
    pat = randLine();
    applyStimulus(0, 1, 64'(MB) + 64'h40, pat, {64{1'b1}}, 0);
    waitGrant(0);
    clearReqs();
    applyStimulus(1, 0, 'h40, '0, '0, 5);
    waitGrant(1);
    clearReqs();
    resp_ready = 1'b1;
    waitResp(lat);
    checkOutput("wrap_data", resp_rdata, pat);
    drain();

    // Reset with three reads in flight: none may surface, memory survives.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(3, 0, 'h40, '0, '0, r + 1);
      waitGrant(3);
    end
    clearReqs();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      checkOutput("rst_no_stale", resp_valid, 0);
    end
    applyStimulus(3, 0, 'h40, '0, '0, 9);
    waitGrant(3);
    clearReqs();
    waitResp(lat);
    checkOutput("rst_mem_kept", resp_rdata, pat);
    drain();

    // Random traffic over eight initialised lines, with aliased addresses.
    for (int l = 0; l < 8; l++) begin
      clearReqs();
      applyStimulus(0, 1, AW'(l * LB), randLine(), {64{1'b1}}, 0);
      waitGrant(0);
    end
    clearReqs();
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1)
          applyStimulus(p, $urandom_range(0, 1) == 1,
                        64'($urandom_range(0, 3)) * 64'(MB) + 64'($urandom_range(0, 7) * LB)
                          + 64'($urandom_range(0, 63)),
                        randLine(), {$urandom, $urandom}, $urandom_range(0, 15));
        else
          dropReq(p);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      stepCycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_memory_mp.md
# shared_memory_mp

Multi-port successor to the single-port line memory. It serves NUM_PORTS requesters (L2 slices, DMA, test loader) through a round-robin arbiter. Writes are byte-masked, and up to RESP_DEPTH reads can be in flight behind a fixed-latency pipeline. Responses carry the port id and tag and are buffered in a FIFO with backpressure. It sits below the coherence interconnect as the backing store for all cores.

## Interface
- NUM_PORTS, 4: requester count, ≥1.
- MEM_BYTES, 8*1024*1024: capacity, power of two.
- LINE_BYTES, 64: line size, power of two.
- ADDR_WIDTH, 64: byte address width.
- DATA_WIDTH, LINE_BYTES*8: line data width.
- READ_LATENCY, 4: accept-to-FIFO-entry cycles, ≥1.
- RESP_DEPTH, 4: maximum outstanding reads, counting pipeline and FIFO together; ≥1.
- TAG_WIDTH, 4: request tag width.
- PW = max(1,$clog2(NUM_PORTS)): derived port id width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_write  in  NUM_PORTS  1=write, 0=read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  byte address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write line; byte i = bits [i*8 +: 8].
- req_be  in  NUM_PORTS*LINE_BYTES  per-byte write enables; ignored for reads.
- req_tag  in  NUM_PORTS*TAG_WIDTH  tag echoed on the read response.
- req_ready  out  NUM_PORTS  one-hot grant; a request is accepted when req_valid&req_ready at a rising edge.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  consumer accepts the head.
- resp_rdata  out  DATA_WIDTH  read line.
- resp_port  out  PW  originating port.
- resp_tag  out  TAG_WIDTH  originating tag.

## Operation
- Address decode:
  - line index = addr[OFFSET_BITS +: INDEX_BITS].
  - Offset bits and bits above the index are ignored, so addresses wrap modulo MEM_BYTES.
- Eligibility:
  - Port p is eligible if req_valid[p] is set and either it is a write, or it is a read and outstanding < RESP_DEPTH.
  - outstanding = reads in the pipeline + FIFO occupancy, as registered at the start of the cycle.
  - A same-cycle FIFO pop does not free a credit until the next cycle.
- Arbitration:
  - Round-robin over eligible ports, starting from pointer rr.
  - Exactly one grant per cycle, or none.
  - After a grant to port g, rr <= (g+1) mod NUM_PORTS. rr is unchanged when no grant is made.
  - A credit-blocked read does not stall writes on other ports.
- req_ready is combinational from req_valid, req_write and state. A requester must not make req_valid depend on req_ready.
- Write:
  - At the accept edge, bytes with be=1 are updated and bytes with be=0 keep their value.
  - No response is generated.
  - All-zero be is a legal no-op.
- Read:
  - The line is sampled at the accept edge, so it reflects every write accepted at earlier edges.
  - The sampled data plus {port, tag} enter a READ_LATENCY-stage valid/data shift pipeline.
  - At the pipeline output, the entry is pushed into the response FIFO.
  - The FIFO cannot overflow, because credits bound pipeline+FIFO to ≤ RESP_DEPTH.
- Responses leave in accept order. There is no reordering between ports.
- resp_rdata/resp_port/resp_tag are driven to 0 whenever resp_valid=0.
- Memory contents are not initialised or reset. Reads of never-written bytes return X in simulation.
- Reset (rst_n=0 at an edge):
  - rr=0, pipeline valids cleared, FIFO emptied, outstanding=0.
  - While rst_n=0, req_ready=0 and resp_valid=0.
  - In-flight reads are discarded and never respond.
  - Writes are not accepted during reset.

## Timing
- Write accepted at edge T is visible to a read accepted at edge T+1 or later.
- Read accepted at edge T enters the FIFO at edge T+READ_LATENCY. resp_valid=1 in the cycle after that edge.
- With resp_ready held at 1: one response per cycle, back-to-back.
- Full pipelined throughput needs RESP_DEPTH ≥ READ_LATENCY+1 (one pop cycle).
- Head is held stable while resp_valid=1 and resp_ready=0.
- Pop occurs at an edge where resp_valid&resp_ready. A simultaneous push in the same cycle is legal and occupancy stays the same.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_port=0, resp_tag=0.

## Test plan
- Byte-mask write:
  - Stimulus: port 0 writes 0x1000 with all bytes 0xAA and be=all-ones. Port 1 then writes 0x1000 with bytes 0x55 and be=0x0F. Port 2 then reads 0x1000 with tag 3.
  - Required: resp_valid after READ_LATENCY edges; bytes 0–3=0x55, bytes 4–63=0xAA; resp_port=2, resp_tag=3.
- Round-robin:
  - Stimulus: all 4 ports hold write requests continuously from reset.
  - Required: grants in order 0,1,2,3,0,…, one per cycle.
- Credit limit (RESP_DEPTH=4, resp_ready=0):
  - Stimulus: port 0 issues 6 reads, while port 1 issues a write.
  - Required: exactly 4 reads are accepted. After that, port 0's req_ready stays 0, but port 1's write is granted.
  - Then raise resp_ready: the remaining reads are accepted, and responses arrive in accept order with correct tags.
- Backpressure:
  - Stimulus: toggle resp_ready randomly during a 4-read stream.
  - Required: head data, port and tag stay stable while stalled; no response is lost or duplicated.
- Address wrap: a write to MEM_BYTES+0x40 and a read from 0x40 return the same line.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for 1 cycle with 3 reads in flight.
  - Required: resp_valid=0 afterwards and no stale responses. Memory still holds the data written before reset.
